vga_timing_recover: RTL and testbench
=====================================

# vga_timing_recover

Sink-side counterpart of the VGA timing generator. It samples a VGA stream (active-low h_sync/v_sync plus 1-bit r/g/b) on the pixel clock and rebuilds the pixel coordinates from the sync edges. It measures line and frame periods, runs a lock state machine, and emits registered coordinates, a data-enable and gated colour bits. It sits at the input of the capture/overlay path and can loop back the timing generator's output as a self-check.

## Interface
- H_TOTAL, 800: pixels per line.
- V_TOTAL, 525: lines per frame.
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.
- H_SYNC_X, 660: pixel index assigned to the first sample with h_sync low.
- V_SYNC_Y, 494: line index assigned on the first sample with v_sync low.
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  reset; one clock; asynchronous, active-high.
- h_sync, v_sync  in  1 each  active-low syncs, one sample per clk.
- r, g, b  in  1 each  colour samples.
- x, y  out  10 each  recovered coordinates of the sample registered this cycle.
- de  out  1  locked and x<H_ACTIVE and y<V_ACTIVE.
- r_out, g_out, b_out  out  1 each  colour gated by de.
- locked  out  1  lock FSM in LOCKED.
- frame_start  out  1  one-cycle pulse when the x=0,y=0 sample is output.
- err_cnt  out  8  count of lock losses; saturates at 255.

## Operation
- Edge detect: registered hs_q/vs_q (reset 1). h_fall = hs_q & ~h_sync, v_fall = vs_q & ~v_sync, evaluated on the current input sample.
- hcnt (10 b): on h_fall load H_SYNC_X. Otherwise, if hcnt==H_TOTAL-1 then 0, else +1.
- hwrap = the increment case with hcnt==H_TOTAL-1.
- vcnt (10 b): on v_fall load V_SYNC_Y. This takes priority over a simultaneous hwrap. On hwrap without v_fall: if vcnt==V_TOTAL-1 then 0, else +1.
- hper (11 b): counts samples since the last h_fall; saturates at 2047. On h_fall, line_ok = (hper+1 == H_TOTAL), then hper clears to 0.
- vper (11 b): counts h_fall events since the last v_fall; saturates. On v_fall, frame_ok = (vper == V_TOTAL), then vper clears.
- bad_line: sticky flag, set by any h_fall with line_ok=0, cleared on v_fall.
- The first h_fall and the first v_fall after reset only start measurement; they are never judged.
- Lock FSM:
  - UNLOCKED: first v_fall -> ACQUIRE.
  - ACQUIRE: next v_fall with frame_ok and no bad_line (including the current line) -> LOCKED. Next v_fall otherwise -> stay in ACQUIRE and restart the frame.
  - LOCKED: any h_fall with line_ok=0, or any v_fall with frame_ok=0 -> UNLOCKED, and err_cnt increments.
  - No v_fall for 2*V_TOTAL*H_TOTAL samples (timeout counter, 21 b) -> UNLOCKED, and err_cnt increments only if the FSM was LOCKED.
- Counters run in every state; only de, frame_start and locked depend on the FSM.
- rst mid-frame: everything returns to reset values immediately. Reacquisition takes a full frame after the next v_fall.

## Timing
- Latency: 1 cycle. For the input sample at edge n, x/y/de/r_out/g_out/b_out show it after edge n+1.
- x = hcnt and y = vcnt as applied to that sample.
- r_out = r & de_next, and likewise for g_out and b_out.
- frame_start = 1 for exactly the cycle x==0, y==0, locked==1.
- locked rises on the cycle after the qualifying v_fall sample. It falls on the cycle after the offending edge.
- Reset values:
  - x=0, y=0, all outputs 0.
  - FSM=UNLOCKED.
  - hcnt=0, vcnt=0, hper=0, vper=0, err_cnt=0, timeout=0.
  - hs_q=vs_q=1.

## Test plan
- Loopback from the timing generator (800x525, h low x 659..755, v low y 494..495) -> locked=1 after the second v_fall. After that, x/y track the generator's counters with the fixed offset, frame_start pulses every 420000 cycles, and de is high 307200 cycles per frame.
- Lock at steady state, r=g=b=1 constantly -> r_out is high only when x<640 and y<480. r_out=0 at x=640 and at y=480.
- While locked, one line shortened to 799 samples -> locked falls 1 cycle after that h_fall, err_cnt=1, and relock follows after one clean frame.
- Syncs held high after lock -> locked drops after 840000 samples, err_cnt increments once, and x/y keep free-running.
- rst asserted at x=300, y=200 mid-frame -> all outputs 0 asynchronously. After release, locked stays 0 until the ACQUIRE frame completes.
- A v_fall on the same sample as hwrap -> vcnt loads 494, not 0 or 495.

Source files
------------

// File: rtl/vga_timing_recover.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_recover
// Brief   : Rebuilds pixel coordinates from a sampled VGA stream's sync edges,
//           judges line/frame periods and tracks lock.
// Revision: 1.0 - initial release
// ============================================================================
module vga_timing_recover #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_SYNC_X = 660,
    parameter int V_SYNC_Y = 494
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic       r,
    input  logic       g,
    input  logic       b,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic       r_out,
    output logic       g_out,
    output logic       b_out,
    output logic       locked,
    output logic       frame_start,
    output logic [7:0] err_cnt
);

    localparam logic [9:0]  C_H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  C_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  C_H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0]  C_V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]  C_HSX     = 10'(H_SYNC_X);
    localparam logic [9:0]  C_VSY     = 10'(V_SYNC_Y);
    localparam logic [11:0] C_H_TOT   = 12'(H_TOTAL);
    localparam logic [10:0] C_V_TOT   = 11'(V_TOTAL);
    localparam logic [10:0] C_PER_MAX = 11'h7FF;
    localparam logic [20:0] C_TO_LAST = 21'(2 * V_TOTAL * H_TOTAL - 1);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    logic        hs_q, vs_q;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [10:0] hper_q, hper_d, vper_q, vper_d;
    logic        h_seen_q, h_seen_d, bad_line_q, bad_line_d;
    logic [20:0] to_q, to_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  err_q, err_d;
    logic        de_q, de_d, r_q, r_d, g_q, g_d, b_q, b_d, fs_q, fs_d;

    logic h_fall, v_fall, hwrap, line_ok, line_bad, frame_ok, to_hit, lose;

    // Measurement datapath; counters free-run regardless of lock state.
    always_comb begin
        h_fall     = hs_q & ~h_sync;
        v_fall     = vs_q & ~v_sync;
        hwrap      = ~h_fall && (hcnt_q == C_H_LAST);
        hcnt_d     = h_fall ? C_HSX : (hwrap ? 10'd0 : hcnt_q + 10'd1);
        vcnt_d     = vcnt_q;
        if (v_fall) begin
            vcnt_d = C_VSY;
        end else if (hwrap) begin
            vcnt_d = (vcnt_q == C_V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end
        hper_d     = h_fall ? 11'd0 : ((hper_q == C_PER_MAX) ? hper_q : hper_q + 11'd1);
        line_ok    = ({1'b0, hper_q} + 12'd1) == C_H_TOT;
        // The very first h_fall after reset only opens the measurement window.
        line_bad   = h_fall & h_seen_q & ~line_ok;
        h_seen_d   = h_seen_q | h_fall;
        vper_d     = vper_q;
        if (v_fall) begin
            vper_d = 11'd0;
        end else if (h_fall && (vper_q != C_PER_MAX)) begin
            vper_d = vper_q + 11'd1;
        end
        frame_ok   = (vper_q == C_V_TOT);
        bad_line_d = v_fall ? 1'b0 : (bad_line_q | line_bad);
        to_hit     = ~v_fall && (to_q == C_TO_LAST);
        to_d       = (v_fall || to_hit) ? 21'd0 : to_q + 21'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lose    = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (v_fall) state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (to_hit) begin
                    state_d = ST_UNLOCKED;
                end else if (v_fall && frame_ok && !bad_line_q && !line_bad) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (line_bad || (v_fall && !frame_ok) || to_hit) begin
                    state_d = ST_UNLOCKED;
                    lose    = 1'b1;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    // Outputs are qualified with the post-transition state so they drop together with locked.
    always_comb begin
        de_d  = (state_d == ST_LOCKED) && (hcnt_d < C_H_ACT) && (vcnt_d < C_V_ACT);
        r_d   = r & de_d;
        g_d   = g & de_d;
        b_d   = b & de_d;
        fs_d  = (state_d == ST_LOCKED) && (hcnt_d == 10'd0) && (vcnt_d == 10'd0);
        err_d = (lose && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            hcnt_q     <= 10'd0;
            vcnt_q     <= 10'd0;
            hper_q     <= 11'd0;
            vper_q     <= 11'd0;
            h_seen_q   <= 1'b0;
            bad_line_q <= 1'b0;
            to_q       <= 21'd0;
            err_q      <= 8'd0;
            de_q       <= 1'b0;
            r_q        <= 1'b0;
            g_q        <= 1'b0;
            b_q        <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            hs_q       <= h_sync;
            vs_q       <= v_sync;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            hper_q     <= hper_d;
            vper_q     <= vper_d;
            h_seen_q   <= h_seen_d;
            bad_line_q <= bad_line_d;
            to_q       <= to_d;
            err_q      <= err_d;
            de_q       <= de_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            fs_q       <= fs_d;
        end
    end

    assign x           = hcnt_q;
    assign y           = vcnt_q;
    assign de          = de_q;
    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign locked      = (state_q == ST_LOCKED);
    assign frame_start = fs_q;
    assign err_cnt     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_recover.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_timing_recover
// Brief   : Directed bench on a shrunken 20x12 raster driven by a local generator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_timing_recover;

    localparam int H_T  = 20;
    localparam int V_T  = 12;
    localparam int H_A  = 12;
    localparam int V_A  = 8;
    localparam int HSX  = 14;
    localparam int VSY  = 9;

    logic       clk, rst, h_sync, v_sync, r, g, b;
    logic [9:0] x, y;
    logic       de, r_out, g_out, b_out, locked, frame_start;
    logic [7:0] err_cnt;

    vga_timing_recover #(
        .H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACTIVE(H_A), .V_ACTIVE(V_A),
        .H_SYNC_X(HSX), .V_SYNC_Y(VSY)
    ) dut (
        .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync),
        .r(r), .g(g), .b(b), .x(x), .y(y), .de(de),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .locked(locked), .frame_start(frame_start), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         tx;
        int         ty;
        logic       ir, ig, ib;
        logic [9:0] ex, ey;
        logic       ede, er, eg, eb, efs;
    } vec_t;

    vec_t tbl[7];
    int   n_tests, n_fail;
    int   gx, gy;
    logic short_line, force_high, force_v_low;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // One generator sample: h low for 3 pixels from HSX, v low for lines VSY..VSY+1.
    task automatic step(input logic ir, input logic ig, input logic ib);
        h_sync = force_high ? 1'b1 : !(gx >= HSX && gx < HSX + 3);
        v_sync = force_v_low ? 1'b0 : (force_high ? 1'b1 : !(gy == VSY || gy == VSY + 1));
        r = ir; g = ig; b = ib;
        @(posedge clk);
        #1;
        if (gx == H_T - 1 || (short_line && gx == H_T - 2)) begin
            gx = 0;
            short_line = 1'b0;
            gy = (gy == V_T - 1) ? 0 : gy + 1;
        end else begin
            gx++;
        end
    endtask

    task automatic goto_pos(input int tx, input int ty);
        int n;
        n = 0;
        while (!(gx == tx && gy == ty) && n < 1000) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("goto_reached", (gx == tx && gy == ty), 1);
    endtask

    // Two v_falls: the first enters ACQUIRE, the second locks.
    task automatic acquire_lock(input string tag);
        goto_pos(0, VSY);
        step(1'b0, 1'b0, 1'b0);
        chk({tag, "_acq_locked"}, locked, 0);
        goto_pos(0, VSY);
        chk({tag, "_pre_locked"}, locked, 0);
        step(1'b0, 1'b0, 1'b0);
        chk({tag, "_locked"}, locked, 1);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        gx = 0; gy = 0;
        short_line = 1'b0; force_high = 1'b0; force_v_low = 1'b0;
        rst = 1'b1; h_sync = 1'b1; v_sync = 1'b1; r = 1'b0; g = 1'b0; b = 1'b0;

        //            tx  ty  r  g  b  ex  ey de er eg eb fs
        tbl[0] = '{14, 9, 1, 1, 1, 14, 9, 0, 0, 0, 0, 0};
        tbl[1] = '{19, 11, 1, 0, 1, 19, 11, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1};
        tbl[3] = '{3, 2, 0, 1, 1, 3, 2, 1, 0, 1, 1, 0};
        tbl[4] = '{11, 7, 1, 1, 0, 11, 7, 1, 1, 1, 0, 0};
        tbl[5] = '{12, 7, 1, 1, 1, 12, 7, 0, 0, 0, 0, 0};
        tbl[6] = '{0, 8, 1, 1, 1, 0, 8, 0, 0, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_de", de, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_err", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        acquire_lock("init");

        for (int i = 0; i < 7; i++) begin
            goto_pos(tbl[i].tx, tbl[i].ty);
            step(tbl[i].ir, tbl[i].ig, tbl[i].ib);
            chk($sformatf("vec%0d_x", i), x, tbl[i].ex);
            chk($sformatf("vec%0d_y", i), y, tbl[i].ey);
            chk($sformatf("vec%0d_de", i), de, tbl[i].ede);
            chk($sformatf("vec%0d_r", i), r_out, tbl[i].er);
            chk($sformatf("vec%0d_g", i), g_out, tbl[i].eg);
            chk($sformatf("vec%0d_b", i), b_out, tbl[i].eb);
            chk($sformatf("vec%0d_fs", i), frame_start, tbl[i].efs);
            chk($sformatf("vec%0d_locked", i), locked, 1);
        end

        // Line 3 is cut to 19 samples; the h_fall on line 4 must break lock.
        goto_pos(18, 3);
        short_line = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        goto_pos(HSX, 4);
        chk("short_pre_locked", locked, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("short_locked", locked, 0);
        chk("short_err", err_cnt, 1);
        chk("short_x", x, HSX);
        chk("short_y", y, 4);
        acquire_lock("relock");
        chk("relock_err", err_cnt, 1);

        // Asynchronous reset mid-frame.
        goto_pos(6, 3);
        step(1'b0, 1'b0, 1'b0);
        chk("mid_pre_x", x, 6);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_x", x, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_de", de, 0);
        chk("mid_rst_err", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        acquire_lock("post_rst");

        // Syncs held high: lock holds 479 samples, drops on the 480th.
        force_high = 1'b1;
        repeat (2 * V_T * H_T - 1) step(1'b0, 1'b0, 1'b0);
        chk("to_pre_locked", locked, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("to_locked", locked, 0);
        chk("to_err", err_cnt, 1);
        chk("to_x", x, 0);
        chk("to_y", y, VSY);

        // v_fall coincident with a horizontal wrap must load VSY.
        goto_pos(19, 2);
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_pre_x", x, 19);
        chk("wrap_pre_y", y, 2);
        force_v_low = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_x", x, 0);
        chk("wrap_y", y, VSY);
        chk("wrap_err", err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
